// File: rtl/filter2d_pkg.sv
// Shared constants for the 2D filter pipeline: default frame geometry and
// the sink capture FSM state encodings.
package filter2d_pkg;

  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;
  localparam int AW_DEF    = 16;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

endpackage

// File: rtl/filter2d_sink_mem.sv
// Result RAM for the filter sink: 2**AW x 8, one write port, one registered
// read port with read-first behaviour on a same-address collision.
module filter2d_sink_mem
  import filter2d_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read stage: the non-blocking write above lands after this sample, so a
  // colliding read returns the previous contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= 8'h00;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/filter2d_sink.sv
// Frame capture sink for the 2D filter output stream with host readback.
// Optional running checksum on o_sum when FILTER2D_SINK_CHECKSUM_EN is defined.
module filter2d_sink
  import filter2d_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_strb,
  input  logic [7:0]    i_data,
  input  logic          clr,
  input  logic          h_rd,
  input  logic [AW-1:0] h_addr,
  output logic [7:0]    h_rdata,
  output logic          h_rvalid,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [15:0]   o_sum
);

  localparam int              FRAME     = IMG_W * IMG_H;
  localparam logic [AW-1:0]   LAST_ADDR = AW'(FRAME - 1);
  localparam logic [AW:0]     FRAME_N   = (AW + 1)'(FRAME);

  logic [1:0]    state;
  logic [AW-1:0] wr_addr;
  logic          err;
  logic          wr_en;
  logic          rd_vld_p1;
  logic          oob_p1;
  logic [7:0]    mem_rdata;

  // clr wins over a coincident strobe, and nothing is stored once the frame is full.
  assign wr_en = i_strb && !clr && (state != S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      wr_addr <= '0;
      err     <= 1'b0;
    end else if (clr) begin
      state   <= S_IDLE;
      wr_addr <= '0;
      err     <= 1'b0;
    end else if (wr_en) begin
      if (wr_addr == LAST_ADDR) begin
        state   <= S_DONE;
        wr_addr <= '0;
      end else begin
        state   <= S_CAPTURE;
        wr_addr <= wr_addr + 1'b1;
      end
    end else if (i_strb && state == S_DONE) begin
      err <= 1'b1;
    end
  end

  assign o_busy = (state == S_CAPTURE);
  assign o_done = (state == S_DONE);
  assign o_err  = err;

  filter2d_sink_mem #(
    .AW(AW)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_en),
    .waddr(wr_addr),
    .wdata(i_data),
    .re   (h_rd),
    .raddr(h_addr),
    .rdata(mem_rdata)
  );

  // Read stage p1: valid and the out-of-frame flag travel with the RAM output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_p1 <= 1'b0;
      oob_p1    <= 1'b0;
    end else begin
      rd_vld_p1 <= h_rd;
      if (h_rd) oob_p1 <= ({1'b0, h_addr} >= FRAME_N);
    end
  end

  assign h_rvalid = rd_vld_p1;
  assign h_rdata  = oob_p1 ? 8'h00 : mem_rdata;

`ifdef FILTER2D_SINK_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sum_q <= 16'h0000;
    else if (clr)   sum_q <= 16'h0000;
    else if (wr_en) sum_q <= sum_q + {8'h00, i_data};
  end

  assign o_sum = sum_q;
`else
  assign o_sum = 16'h0000;
`endif

endmodule
